// File: rtl/memory_slave_responder.sv
// memory_slave_responder
// Slave end of the memory req/ack handshake: a single-port word memory that
// answers one master. Each accepted request is completed by a one-cycle ack
// pulse exactly LATENCY clock edges after the acceptance edge. Reads drive the
// shared data bus only while ack is high; at every other time the bus is
// released to 'z.
//
// Optional feature: define MEM_RESP_PARITY_EN to check even parity of write
// payloads. A write whose parity bit (MSB) does not match the payload is
// dropped and raises the sticky par_err flag. Without the macro every bit of
// the word is stored verbatim and par_err is tied low.

module memory_slave_responder #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 257,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic [ADDR_W-1:0] addr,
  input  logic              w_en,
  output logic              ack,
  inout  wire  [DATA_W-1:0] data,
  output logic              par_err
);

  localparam int IDX_W = $clog2(DEPTH);

  // Counter value loaded at acceptance; WAIT lasts LATENCY cycles in total.
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  // Depth widened by one bit so that DEPTH == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACK,
    S_RELEASE
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [3:0]        r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic              r_wen;
  logic [DATA_W-1:0] r_writeData;
  logic [DATA_W-1:0] r_readData;
  logic [DATA_W-1:0] r_mem [0:DEPTH-1];

  logic              w_inRange;
  logic [IDX_W-1:0]  w_idx;
  logic              w_commit;
  logic              w_parOk;
  logic              w_memWe;
  logic              w_drive;

  // Only the low index bits address the array; out-of-range is caught by the
  // full-width compare, so high addresses never alias onto real words.
  assign w_inRange = ({1'b0, r_addr} < DEPTH_L);
  assign w_idx     = r_addr[IDX_W-1:0];

  // The edge that moves WAIT into ACK is where writes commit and reads fetch.
  assign w_commit  = (r_state == S_WAIT) && (w_next == S_ACK);

`ifdef MEM_RESP_PARITY_EN
  // Even parity: payload ones plus the parity bit must give an even count.
  assign w_parOk = ((^r_writeData[DATA_W-2:0]) == r_writeData[DATA_W-1]);
`else
  assign w_parOk = 1'b1;
`endif

  // A write in reset is never committed, even if the clock edge coincides.
  assign w_memWe = w_commit && r_wen && w_inRange && w_parOk && !reset;

  // Next-state logic for the IDLE -> WAIT -> ACK -> RELEASE handshake.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (req) begin
          w_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_next = S_ACK;
        end
      end
      S_ACK: begin
        w_next = S_RELEASE;
      end
      S_RELEASE: begin
        if (!req) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Outputs decoded from the state register: ack for the single ACK cycle,
  // bus drive only during the ACK cycle of a read.
  always_comb begin
    ack     = 1'b0;
    w_drive = 1'b0;
    if (r_state == S_ACK) begin
      ack     = 1'b1;
      w_drive = !r_wen;
    end
  end

  assign data = w_drive ? r_readData : {DATA_W{1'bz}};

  // State register, latency counter and request capture; the request fields
  // are latched once at acceptance so later bus activity cannot disturb them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_addr      <= '0;
      r_wen       <= 1'b0;
      r_writeData <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (req) begin
            r_addr <= addr;
            r_wen  <= w_en;
            r_cnt  <= CNT_LOAD;
            if (w_en) begin
              r_writeData <= data;
            end
          end
        end
        S_WAIT: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: begin
          r_cnt <= 4'd0;
        end
      endcase
    end
  end

  // Memory array and read register; the array is deliberately not reset so
  // its contents survive a reset. Out-of-range reads return all zeros.
  always_ff @(posedge clk) begin
    if (w_memWe) begin
      r_mem[w_idx] <= r_writeData;
    end
    if (w_commit) begin
      r_readData <= w_inRange ? r_mem[w_idx] : '0;
    end
  end

`ifdef MEM_RESP_PARITY_EN
  logic r_parErr;

  // Sticky parity error, raised on the ACK edge of a bad-parity write and
  // cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_parErr <= 1'b0;
    end else if (w_commit && r_wen && !w_parOk) begin
      r_parErr <= 1'b1;
    end
  end

  assign par_err = r_parErr;
`else
  assign par_err = 1'b0;
`endif

endmodule
